// File: rtl/tl_a_burst_arbiter.sv
// Round-robin TileLink A-channel arbiter for NumHosts request streams.
// Multi-beat data-carrying requests hold the grant until their last beat.
module tl_a_burst_arbiter #(
   parameter int NumHosts     = 4,
   parameter int DataWidth    = 64,
   parameter int SizeWidth    = 3,
   parameter int MaxSize      = 6,
   parameter int PayloadWidth = 128
) (
   input  logic                                    clk_i,
   input  logic                                    rst_i,
   input  logic [NumHosts-1:0]                     host_valid_i,
   output logic [NumHosts-1:0]                     host_ready_o,
   input  logic [NumHosts-1:0][2:0]                host_opcode_i,
   input  logic [NumHosts-1:0][SizeWidth-1:0]      host_size_i,
   input  logic [NumHosts-1:0][PayloadWidth-1:0]   host_payload_i,
   output logic                                    dev_valid_o,
   input  logic                                    dev_ready_i,
   output logic [2:0]                              dev_opcode_o,
   output logic [SizeWidth-1:0]                    dev_size_o,
   output logic [PayloadWidth-1:0]                 dev_payload_o,
   output logic [$clog2(NumHosts)-1:0]             gnt_idx_o,
   output logic                                    locked_o
);

   localparam int IdxW         = $clog2(NumHosts);
   localparam int NonBurstSize = $clog2(DataWidth / 8);
   localparam int MaxBeats     = 2 ** (MaxSize - NonBurstSize);
   localparam int BeatW        = $clog2(MaxBeats) + 1;

   typedef enum logic {
      IDLE,
      LOCKED
   } state_t;

   state_t            state_q;
   logic [IdxW-1:0]   rr_ptr_q;
   logic [IdxW-1:0]   locked_idx_q;
   logic [BeatW-1:0]  beats_left_q;

   logic [IdxW-1:0]   arb_idx;
   logic              arb_found;
   logic [IdxW-1:0]   gnt_idx;
   logic [BeatW-1:0]  gnt_beats;
   logic              hs;

   function automatic logic [IdxW-1:0] next_idx(
      input logic [IdxW-1:0] i
   );
      if (int'(i) == NumHosts - 1) begin
         return '0;
      end
      return i + 1'b1;
   endfunction

   // Opcodes 0..3 carry data; everything else is a single beat.
   function automatic logic [BeatW-1:0] beat_cnt(
      input logic [2:0]           op,
      input logic [SizeWidth-1:0] sz
   );
      logic [BeatW-1:0] n;
      n = BeatW'(1);
      if (!op[2] && int'(sz) > NonBurstSize) begin
         n = BeatW'(1 << (int'(sz) - NonBurstSize));
      end
      return n;
   endfunction

   always_comb begin : arb_search
      logic [IdxW-1:0] cand;
      arb_idx   = rr_ptr_q;
      arb_found = 1'b0;
      cand      = '0;
      for (int i = 0; i < NumHosts; i++) begin
         cand = IdxW'((int'(rr_ptr_q) + i) % NumHosts);
         if (!arb_found && host_valid_i[cand]) begin
            arb_idx   = cand;
            arb_found = 1'b1;
         end
      end
   end

   assign gnt_idx = (state_q == LOCKED) ? locked_idx_q : arb_idx;

   assign dev_valid_o = (state_q == LOCKED)
                      ? host_valid_i[locked_idx_q]
                      : arb_found;

   assign dev_opcode_o  = host_opcode_i[gnt_idx];
   assign dev_size_o    = host_size_i[gnt_idx];
   assign dev_payload_o = host_payload_i[gnt_idx];
   assign gnt_idx_o     = gnt_idx;
   assign locked_o      = (state_q == LOCKED);

   always_comb begin
      host_ready_o          = '0;
      host_ready_o[gnt_idx] = dev_ready_i & ~rst_i;
   end

   assign hs        = dev_valid_o & dev_ready_i;
   assign gnt_beats = beat_cnt(dev_opcode_o, dev_size_o);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         rr_ptr_q     <= '0;
         locked_idx_q <= '0;
         beats_left_q <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (hs) begin
                  if (gnt_beats > BeatW'(1)) begin
                     state_q      <= LOCKED;
                     locked_idx_q <= gnt_idx;
                     beats_left_q <= gnt_beats - 1'b1;
                  end else begin
                     rr_ptr_q <= next_idx(gnt_idx);
                  end
               end
            end
            LOCKED: begin
               if (hs) begin
                  beats_left_q <= beats_left_q - 1'b1;
                  if (beats_left_q == BeatW'(1)) begin
                     state_q  <= IDLE;
                     rr_ptr_q <= next_idx(locked_idx_q);
                  end
               end
            end
         endcase
      end
   end

   for (genvar h = 0; h < NumHosts; h++) begin : g_size_chk
      a_legal_size: assert property (
         @(posedge clk_i) disable iff (rst_i)
         host_valid_i[h] |-> int'(host_size_i[h]) <= MaxSize
      );
   end

   a_ready_onehot: assert property (
      @(posedge clk_i) $onehot0(host_ready_o)
   );

endmodule

// File: doc/tl_a_burst_arbiter.md
Name: tl_a_burst_arbiter

Overview:
- Round-robin arbiter that merges NumHosts TileLink A-channel request streams onto one A-channel port. A typical placement is in front of a width adapter or crossbar port.
- Grant is burst-aware. Once the first beat of a multi-beat data-carrying request is accepted, the grant stays locked to that host until the last beat is accepted, so bursts are never interleaved.
- Exposes the granted index so downstream logic can tag the request or route responses.

Parameters:
- NumHosts, 4, number of requesting hosts (>=2).
- DataWidth, 64, A-channel data width in bits; NonBurstSize = $clog2(DataWidth/8).
- SizeWidth, 3, width of the size field (log2 bytes).
- MaxSize, 6, largest legal size; MaxBeats = 2**(MaxSize-NonBurstSize).
- PayloadWidth, 128, width of all other A fields, carried unchanged (param, source, address, mask, data, corrupt).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset; one clock, synchronous, active-high.
- host_valid_i  in  NumHosts  per-host request valid.
- host_ready_o  out  NumHosts  per-host ready; at most one bit high.
- host_opcode_i  in  NumHosts x 3  per-host A opcode.
- host_size_i  in  NumHosts x SizeWidth  per-host A size.
- host_payload_i  in  NumHosts x PayloadWidth  per-host remaining A fields.
- dev_valid_o  out  1  merged valid.
- dev_ready_i  in  1  device ready.
- dev_opcode_o  out  3  opcode of the granted host.
- dev_size_o  out  SizeWidth  size of the granted host.
- dev_payload_o  out  PayloadWidth  payload of the granted host.
- gnt_idx_o  out  $clog2(NumHosts)  index of the granted host; valid while dev_valid_o is high.
- locked_o  out  1  high while a burst is in progress.

Behaviour:
- Beat count of a request:
  - Data-carrying opcodes are PutFull=0, PutPartial=1, ArithmeticData=2, LogicalData=3.
  - For these, beats = 2**(size-NonBurstSize) if size > NonBurstSize, else 1.
  - All other opcodes (Get=4, Intent=5, AcquireBlock=6, AcquirePerm=7) are always 1 beat.
- Counter beats_left is $clog2(MaxBeats)+1 bits wide.
- State IDLE:
  - Grant goes to the first host with valid set, searching from rr_ptr upward and wrapping modulo NumHosts.
  - The grant is combinational, with zero-cycle latency.
  - dev_valid_o = OR of host_valid_i. dev_* fields are muxed from the granted host. host_ready_o[g] = dev_ready_i; all other host_ready_o bits are 0.
- IDLE handshake on a multi-beat request (dev_valid_o && dev_ready_i, beats > 1): go to LOCKED with locked_idx <= g and beats_left <= beats-1.
- IDLE handshake on a single-beat request: stay in IDLE and set rr_ptr <= (g+1) mod NumHosts.
- State LOCKED:
  - gnt_idx_o = locked_idx. Other hosts see ready 0 regardless of their valid.
  - dev_valid_o = host_valid_i[locked_idx]. If the locked host drops valid mid-burst, dev_valid_o goes low and the lock is held; no other host is granted.
  - On each handshake, beats_left decrements.
  - When the handshake happens with beats_left==1: go to IDLE and set rr_ptr <= (locked_idx+1) mod NumHosts.
  - The next grant starts in the following cycle. There is no same-cycle regrant at the end of a burst.
- locked_o = (state==LOCKED).
- The arbiter never drops or duplicates a beat, and never changes fields while dev_valid_o is high without a handshake. In IDLE with dev_ready_i low, the grant may move if a higher-priority host raises valid; this is permitted only because no beat was accepted.
- When no host is valid: dev_valid_o=0, gnt_idx_o=rr_ptr, dev_* fields don't care.
- Reset, including reset asserted mid-burst: state=IDLE, rr_ptr=0, beats_left=0. Outputs during and after reset are dev_valid_o=0 when no host is valid, host_ready_o=0 while rst_i is high, and locked_o=0.
- Sizes larger than MaxSize are illegal; this is checked by assertion only.

Test Plan:
- Single host: host0 issues Get size=6 with dev_ready_i=1 -> granted in the same cycle, 1 handshake, locked_o stays 0, rr_ptr becomes 1.
- Burst lock: host1 issues PutFull size=6 (8 beats at 64-bit) while host2 is continuously valid -> gnt_idx_o=1 for exactly 8 handshakes and host_ready_o[2]=0 throughout; host2 is granted in the cycle after the 8th beat.
- Round-robin fairness: all 4 hosts continuously issue single-beat Gets with dev_ready_i=1 -> grant order 0,1,2,3,0,1,... with one grant per cycle.
- Bubble mid-burst: host0 PutFull size=5 (4 beats) drops valid for 3 cycles after beat 2 while host3 is valid -> dev_valid_o=0 for those cycles, lock held, beats 3-4 come from host0, then host3 is granted.
- Backpressure: dev_ready_i=0 for 5 cycles during beat 1 of a 2-beat burst -> dev fields stable, no counter change, exactly 2 handshakes total.
- Reset mid-burst: assert rst_i after beat 3 of 8 -> next cycle locked_o=0 and rr_ptr=0; a new request from host2 is granted normally.
